// File: rtl/fft_n16_loader.sv
// Serial-to-parallel input stage for fft_n16: collects 16-sample frames
// into a fill bank and ping-pongs them into a holding bank that drives the FFT.
module fft_n16_loader #(
    parameter int W = 16,
    parameter int N = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W-1:0]    s_re,
    input  logic [W-1:0]    s_im,
    input  logic            s_last,
    input  logic            fft_ready,
    output logic [16*W-1:0] x_re,
    output logic [16*W-1:0] x_im,
    output logic            en,
    output logic            frame_err
);

    generate
        if (N != 16) begin : g_bad_n
            $fatal(1, "fft_n16_loader: N must be 16");
        end
    endgenerate

    logic [W-1:0]    fill_re_q [16];
    logic [W-1:0]    fill_re_d [16];
    logic [W-1:0]    fill_im_q [16];
    logic [W-1:0]    fill_im_d [16];
    logic [3:0]      fill_cnt_q;
    logic [3:0]      fill_cnt_d;
    logic            fill_full_q;
    logic            fill_full_d;
    logic [16*W-1:0] hold_re_q;
    logic [16*W-1:0] hold_re_d;
    logic [16*W-1:0] hold_im_q;
    logic [16*W-1:0] hold_im_d;
    logic            out_full_q;
    logic            out_full_d;
    logic            frame_err_q;
    logic            frame_err_d;

    logic            acc;
    logic            issue;
    logic            cnt_last;

    assign en       = out_full_q & fft_ready;
    assign issue    = fill_full_q & (~out_full_q | en);
    assign s_ready  = ~rst & (~fill_full_q | issue);
    assign acc      = s_valid & s_ready;
    assign cnt_last = (fill_cnt_q == 4'd15);

    assign x_re      = hold_re_q;
    assign x_im      = hold_im_q;
    assign frame_err = frame_err_q;

    // Sample 0 of a new frame may land on the issuing edge; the copy
    // below reads the pre-edge bank, so the two never collide.
    always_comb begin
        fill_re_d = fill_re_q;
        fill_im_d = fill_im_q;
        if (acc) begin
            fill_re_d[fill_cnt_q] = s_re;
            fill_im_d[fill_cnt_q] = s_im;
        end
    end

    always_comb begin
        fill_cnt_d  = fill_cnt_q;
        frame_err_d = 1'b0;
        if (acc) begin
            if (cnt_last || s_last) begin
                fill_cnt_d = 4'd0;
            end else begin
                fill_cnt_d = fill_cnt_q + 4'd1;
            end
            frame_err_d = s_last & ~cnt_last;
        end
    end

    always_comb begin
        fill_full_d = fill_full_q;
        if (issue) begin
            fill_full_d = 1'b0;
        end
        if (acc && cnt_last) begin
            fill_full_d = 1'b1;
        end
    end

    always_comb begin
        out_full_d = out_full_q;
        if (en) begin
            out_full_d = 1'b0;
        end
        if (issue) begin
            out_full_d = 1'b1;
        end
    end

    always_comb begin
        hold_re_d = hold_re_q;
        hold_im_d = hold_im_q;
        if (issue) begin
            for (int k = 0; k < 16; k++) begin
                hold_re_d[k*W +: W] = fill_re_q[k];
                hold_im_d[k*W +: W] = fill_im_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        fill_re_q <= fill_re_d;
        fill_im_q <= fill_im_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt_q  <= 4'd0;
            fill_full_q <= 1'b0;
            out_full_q  <= 1'b0;
            frame_err_q <= 1'b0;
            hold_re_q   <= '0;
            hold_im_q   <= '0;
        end else begin
            fill_cnt_q  <= fill_cnt_d;
            fill_full_q <= fill_full_d;
            out_full_q  <= out_full_d;
            frame_err_q <= frame_err_d;
            hold_re_q   <= hold_re_d;
            hold_im_q   <= hold_im_d;
        end
    end

endmodule

// File: tb/tb_fft_n16_loader.sv
// Bench for fft_n16_loader: directed scenarios plus a randomized stream,
// all scored against a frame-level queue model.
module tb_fft_n16_loader;

    localparam int W = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [W-1:0]    s_re = '0;
    logic [W-1:0]    s_im = '0;
    logic            s_last = 1'b0;
    logic            fft_ready = 1'b0;
    logic [16*W-1:0] x_re;
    logic [16*W-1:0] x_im;
    logic            en;
    logic            frame_err;

    fft_n16_loader #(.W(W), .N(16)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready),
        .s_re(s_re), .s_im(s_im), .s_last(s_last),
        .fft_ready(fft_ready),
        .x_re(x_re), .x_im(x_im),
        .en(en), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame-level model: completed frames wait in a queue with the
    // cycle they completed; a frame is launchable two cycles later.
    logic [16*W-1:0] exp_re_q [$];
    logic [16*W-1:0] exp_im_q [$];
    int              exp_cyc_q [$];
    logic [W-1:0]    cur_re [16];
    logic [W-1:0]    cur_im [16];
    int              cur_n = 0;
    logic            err_pend = 1'b0;

    int              cyc = 0;
    int              en_cnt = 0;
    int              err_cnt = 0;
    int              acc_cnt = 0;
    int              nrdy_cnt = 0;
    int              last_acc = 0;
    int              en_hist [$];
    logic [16*W-1:0] en_x_re = '0;
    logic [16*W-1:0] en_x_im = '0;

    always @(negedge clk) begin
        logic            exp_en;
        logic            exp_rdy;
        logic [16*W-1:0] pr;
        logic [16*W-1:0] pi;
        cyc++;
        if (rst) begin
            check("rdy_in_rst", {255'b0, s_ready}, 256'd0);
            exp_re_q.delete();
            exp_im_q.delete();
            exp_cyc_q.delete();
            cur_n    = 0;
            err_pend = 1'b0;
        end else begin
            exp_rdy = (exp_re_q.size() < 2) || fft_ready;
            check("s_ready", {255'b0, s_ready}, {255'b0, exp_rdy});
            check("frame_err", {255'b0, frame_err}, {255'b0, err_pend});
            exp_en = fft_ready && (exp_cyc_q.size() > 0)
                     && (cyc >= exp_cyc_q[0] + 2);
            check("en", {255'b0, en}, {255'b0, exp_en});
            if (exp_en) begin
                check("x_re", x_re, exp_re_q.pop_front());
                check("x_im", x_im, exp_im_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            if (en) begin
                en_cnt++;
                en_hist.push_back(cyc);
                en_x_re = x_re;
                en_x_im = x_im;
            end
            if (frame_err) err_cnt++;
            err_pend = 1'b0;
            if (s_valid && !s_ready) nrdy_cnt++;
            if (s_valid && s_ready) begin
                acc_cnt++;
                last_acc = cyc;
                cur_re[cur_n] = s_re;
                cur_im[cur_n] = s_im;
                cur_n++;
                if (cur_n == 16) begin
                    for (int k = 0; k < 16; k++) begin
                        pr[k*W +: W] = cur_re[k];
                        pi[k*W +: W] = cur_im[k];
                    end
                    exp_re_q.push_back(pr);
                    exp_im_q.push_back(pi);
                    exp_cyc_q.push_back(cyc);
                    cur_n = 0;
                end else if (s_last) begin
                    cur_n    = 0;
                    err_pend = 1'b1;
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] re, input logic [W-1:0] im,
                        input logic last);
        logic ok;
        int   t;
        t       = 0;
        s_valid = 1'b1;
        s_re    = re;
        s_im    = im;
        s_last  = last;
        forever begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            t++;
            if (t > 300) begin
                check("push_timeout", 256'd0, 256'd1);
                break;
            end
        end
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    int sine [16] = '{0, 12539, 23170, 30273, 32767, 30273, 23170, 12539,
                      0, -12539, -23170, -30273, -32767, -30273, -23170,
                      -12539};
    int   e0;
    int   er0;
    int   a0;
    int   nr0;
    int   h0;
    int   t;
    logic rstop;

    initial begin
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_en", {255'b0, en}, 256'd0);
        check("rst_rdy", {255'b0, s_ready}, 256'd1);
        check("rst_x_re", x_re, 256'd0);
        check("rst_x_im", x_im, 256'd0);
        check("rst_err", {255'b0, frame_err}, 256'd0);
        @(posedge clk);
        #1;

        // single sine frame
        fft_ready = 1'b1;
        e0 = en_cnt;
        for (int k = 0; k < 16; k++) push(W'(sine[k]), '0, k == 15);
        idle();
        wait_cyc(6);
        check("sf_en_cnt", 256'(en_cnt - e0), 256'd1);
        check("sf_latency", 256'(en_hist[en_hist.size()-1] - last_acc), 256'd2);
        check("sf_x4", {240'b0, en_x_re[4*W +: W]}, 256'h7fff);
        check("sf_x12", {240'b0, en_x_re[12*W +: W]}, 256'h8001);
        check("sf_im", en_x_im, 256'd0);

        // four frames back to back
        e0  = en_cnt;
        nr0 = nrdy_cnt;
        h0  = en_hist.size();
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 16; k++)
                push(W'(f*16 + k), W'(k), k == 15);
        idle();
        wait_cyc(6);
        check("cs_en_cnt", 256'(en_cnt - e0), 256'd4);
        check("cs_stall", 256'(nrdy_cnt - nr0), 256'd0);
        for (int i = 1; i < 4; i++)
            check("cs_gap", 256'(en_hist[h0+i] - en_hist[h0+i-1]), 256'd16);

        // backpressure
        fft_ready = 1'b0;
        e0 = en_cnt;
        a0 = acc_cnt;
        h0 = en_hist.size();
        fork
            begin
                for (int k = 0; k < 48; k++)
                    push(W'(200 + k), W'(k ^ 5), (k % 16) == 15);
                idle();
            end
            begin
                wait_cyc(40);
                check("bp_acc", 256'(acc_cnt - a0), 256'd32);
                check("bp_no_en", 256'(en_cnt - e0), 256'd0);
                fft_ready = 1'b1;
            end
        join
        wait_cyc(6);
        check("bp_en_cnt", 256'(en_cnt - e0), 256'd3);
        check("bp_consec", 256'(en_hist[h0+1] - en_hist[h0]), 256'd1);
        @(negedge clk);
        check("bp_rdy", {255'b0, s_ready}, 256'd1);
        @(posedge clk);
        #1;

        // early last on sample 5
        e0  = en_cnt;
        er0 = err_cnt;
        for (int k = 0; k < 6; k++) push(W'(100 + k), '0, k == 5);
        for (int k = 0; k < 16; k++) push(W'(300 + k), W'(7), k == 15);
        idle();
        wait_cyc(6);
        check("el_err_cnt", 256'(err_cnt - er0), 256'd1);
        check("el_en_cnt", 256'(en_cnt - e0), 256'd1);
        check("el_x0", {240'b0, en_x_re[0 +: W]}, 256'd300);

        // reset with a held frame and a partial frame
        fft_ready = 1'b0;
        for (int k = 0; k < 16; k++) push(W'(400 + k), '0, k == 15);
        for (int k = 0; k < 9; k++) push(W'(500 + k), '0, 1'b0);
        idle();
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        fft_ready = 1'b1;
        @(negedge clk);
        check("mr_en", {255'b0, en}, 256'd0);
        check("mr_x_re", x_re, 256'd0);
        check("mr_rdy", {255'b0, s_ready}, 256'd1);
        @(posedge clk);
        #1;
        e0 = en_cnt;
        for (int k = 0; k < 16; k++) push(W'(600 + k), W'(k), k == 15);
        idle();
        wait_cyc(6);
        check("mr_en_cnt", 256'(en_cnt - e0), 256'd1);
        check("mr_x0", {240'b0, en_x_re[0 +: W]}, 256'd600);

        // randomized traffic
        e0    = en_cnt;
        rstop = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        wait_cyc($urandom_range(1, 3));
                    end
                    push(W'($urandom), W'($urandom), $urandom_range(0, 59) == 0);
                end
                idle();
                rstop = 1'b1;
            end
            begin
                while (!rstop) begin
                    fft_ready = ($urandom_range(0, 2) != 0);
                    wait_cyc(1);
                end
            end
        join
        fft_ready = 1'b1;
        t = 0;
        while (exp_re_q.size() != 0 && t < 100) begin
            wait_cyc(1);
            t++;
        end
        check("rnd_drain", 256'(exp_re_q.size()), 256'd0);
        check("rnd_launched", {255'b0, (en_cnt - e0) > 10}, 256'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_n16_loader.md
Name: fft_n16_loader

Overview:
Serial-to-parallel input stage that sits directly upstream of fft_n16. It accepts one complex sample per cycle over a valid/ready stream and collects 16 samples into a fill bank. Each complete frame is handed to a holding bank that drives fft_n16's 32 parallel inputs, and the block issues the one-cycle en pulse fft_n16 needs to start a transform. The two banks form a ping-pong pair so back-to-back frames stream at one sample per cycle.

Parameters:
W, `W (16), sample width in bits, two's complement, real and imaginary each.
N, 16, frame length; fixed at 16, and elaboration must fail for any other value.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
s_valid  in  1  input sample valid.
s_ready  out  1  loader can accept a sample this cycle.
s_re  in  W  sample real part.
s_im  in  W  sample imaginary part.
s_last  in  1  marks the final (16th) sample of a frame.
fft_ready  in  1  fft_n16 can take a new frame this cycle.
x_re  out  16*W  held frame, real parts; x_re[k*W +: W] = sample k (k=0 is the first accepted) and maps to x{k}r.
x_im  out  16*W  held frame, imaginary parts; same mapping, to x{k}i.
en  out  1  one-cycle frame strobe to fft_n16.
frame_err  out  1  one-cycle pulse: frame aborted by an early s_last.

Behaviour:
- Internal state: fill bank (16 x 2W), fill_cnt (4 bit), fill_full, hold bank (16 x 2W, drives x_re/x_im), out_full.
- Accept: acc = s_valid & s_ready. Each accept writes {s_re, s_im} to fill bank[fill_cnt].
- Fill counter:
  - On accept with fill_cnt < 15 and s_last=0: fill_cnt increments.
  - On accept with fill_cnt == 15: fill_cnt goes to 0 and fill_full is set. s_last is not required here; its absence is not an error.
- Early last: an accept with s_last=1 and fill_cnt < 15:
  - The sample is written but the partial frame is discarded.
  - fill_cnt goes to 0, fill_full is unchanged (0).
  - frame_err is registered high for exactly the next cycle.
- Launch:
  - en = out_full & fft_ready. This is combinational from a register and an input.
  - x_re/x_im are guaranteed stable throughout the en cycle.
  - At the edge closing the en cycle, out_full clears.
- Issue:
  - issue = fill_full & (~out_full | en).
  - At the issuing edge, the hold bank is loaded with the fill bank (old values), out_full is set, and fill_full clears.
- Ready: s_ready = ~fill_full | issue.
  - A new frame's sample 0 may be accepted on the same edge as the issue. The copy uses pre-edge contents, so there is no corruption.
- Throughput: with s_valid and fft_ready held high, one frame is issued every 16 cycles with no input stall.
- Latency: if the 16th sample is accepted at edge E and the hold bank is empty, the issue happens at E+1 and en is high during the cycle after E+1 (provided fft_ready is high).
- Backpressure: if fft_ready stays low, out_full stays high and the next frame completes into the fill bank. s_ready then drops until en frees the hold bank.
- Simultaneous events:
  - en and issue on the same edge: the hold bank reloads and out_full stays 1. The next en may follow in the next cycle.
  - An early-last accept on the same edge as an issue: the issue proceeds unaffected.
- Reset (asserted at any time, including mid-frame or while stalled):
  - At the next edge: fill_cnt=0, fill_full=0, out_full=0, frame_err=0, x_re=0, x_im=0.
  - This gives en=0 and s_ready=1 once rst deasserts.
  - Fill bank contents are don't-care. A partial frame is lost with no frame_err.
  - While rst=1, s_ready reads 0 and inputs are ignored.

Test Plan:
- Single frame: reset, then stream re = 0,12539,23170,30273,32767,30273,23170,12539,0,-12539,-23170,-30273,-32767,-30273,-23170,-12539 with im=0 and fft_ready=1. Require en high for exactly 1 cycle, 2 cycles after the 16th accept; x_re[4*W +: W]=32767; x_re[12*W +: W]=-32767 (0x8001); all x_im=0.
- Continuous stream: 4 frames back-to-back with re=frame*16+k. Require s_ready to stay 1, en pulses exactly 16 cycles apart, and each held frame to match.
- Backpressure: fft_ready=0 for 40 cycles while streaming. Require s_ready to fall after the 32nd accept and no en. When fft_ready rises, require en on frames 1 and 2 in consecutive cycles, in order, and s_ready to return to 1.
- Early last: assert s_last on sample 5. Require frame_err to pulse 1 cycle and no en; the next 16 samples must form a correct frame with sample 0 at index 0.
- Reset mid-frame: assert rst after 9 samples with a frame pending in the hold bank. Require en=0, x_re=0, s_ready=1 after release, and a fresh 16-sample frame to issue normally.
- Random: random s_valid and fft_ready; the scoreboard must see every completed frame launched exactly once, in order, with no data mismatch.
